// File: rtl/ebpf_operand_extend_ctrl.sv
// Operand extender between eBPF fetch and decode: sign-extends off/imm and
// stitches the two-slot LDDW into one 64-bit immediate.
module ebpf_operand_extend_ctrl #(
  parameter logic [7:0]  LDDW_OPCODE = 8'h18,
  parameter int unsigned INSN_W      = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic [INSN_W-1:0] in_insn,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [7:0]        out_opcode,
  output logic [3:0]        out_dst,
  output logic [3:0]        out_src,
  output logic [63:0]       out_off64,
  output logic [63:0]       out_imm64,
  output logic [1:0]        out_slots,
  output logic              out_err,
  output logic              out_valid,
  input  logic              out_ready
);

  typedef enum logic [0:0] {
    S_FIRST   = 1'b0,
    S_WAIT_HI = 1'b1
  } state_t;

  state_t      state_q;
  logic [7:0]  hold_opcode_q;
  logic [3:0]  hold_dst_q;
  logic [3:0]  hold_src_q;
  logic [15:0] hold_off_q;
  logic [31:0] lo_imm_q;

  logic [7:0]  out_opcode_q;
  logic [3:0]  out_dst_q;
  logic [3:0]  out_src_q;
  logic [63:0] out_off64_q;
  logic [63:0] out_imm64_q;
  logic [1:0]  out_slots_q;
  logic        out_err_q;
  logic        out_valid_q;

  logic [7:0]  in_opcode;
  logic [3:0]  in_dst;
  logic [3:0]  in_src;
  logic [15:0] in_off;
  logic [31:0] in_imm;
  logic [63:0] off64_d;
  logic [63:0] imm64_d;
  logic [63:0] hold_off64_d;
  logic [63:0] lddw_imm64_d;
  logic        hi_malformed_d;
  logic        accept;

  assign in_opcode = in_insn[7:0];
  assign in_dst    = in_insn[11:8];
  assign in_src    = in_insn[15:12];
  assign in_off    = in_insn[31:16];
  assign in_imm    = in_insn[63:32];

  assign off64_d        = {{48{in_off[15]}}, in_off};
  assign imm64_d        = {{32{in_imm[31]}}, in_imm};
  assign hold_off64_d   = {{48{hold_off_q[15]}}, hold_off_q};
  assign lddw_imm64_d   = {in_imm, lo_imm_q};
  // The high LDDW slot must carry nothing but its immediate.
  assign hi_malformed_d = |in_insn[31:0];

  // Depends only on registered state and downstream/flush, never on in_valid.
  assign in_ready = !flush && (!out_valid_q || out_ready);
  assign accept   = in_valid && in_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_FIRST;
      hold_opcode_q <= '0;
      hold_dst_q    <= '0;
      hold_src_q    <= '0;
      hold_off_q    <= '0;
      lo_imm_q      <= '0;
      out_opcode_q  <= '0;
      out_dst_q     <= '0;
      out_src_q     <= '0;
      out_off64_q   <= '0;
      out_imm64_q   <= '0;
      out_slots_q   <= '0;
      out_err_q     <= 1'b0;
      out_valid_q   <= 1'b0;
    end else if (flush) begin
      state_q     <= S_FIRST;
      out_valid_q <= 1'b0;
      out_err_q   <= 1'b0;
    end else begin
      if (out_valid_q && out_ready) begin
        out_valid_q <= 1'b0;
      end
      if (accept) begin
        unique case (state_q)
          S_FIRST: begin
            if (in_opcode == LDDW_OPCODE) begin
              hold_opcode_q <= in_opcode;
              hold_dst_q    <= in_dst;
              hold_src_q    <= in_src;
              hold_off_q    <= in_off;
              lo_imm_q      <= in_imm;
              state_q       <= S_WAIT_HI;
            end else begin
              out_opcode_q <= in_opcode;
              out_dst_q    <= in_dst;
              out_src_q    <= in_src;
              out_off64_q  <= off64_d;
              out_imm64_q  <= imm64_d;
              out_slots_q  <= 2'd1;
              out_err_q    <= 1'b0;
              out_valid_q  <= 1'b1;
            end
          end
          S_WAIT_HI: begin
            out_opcode_q <= hold_opcode_q;
            out_dst_q    <= hold_dst_q;
            out_src_q    <= hold_src_q;
            out_off64_q  <= hold_off64_d;
            out_imm64_q  <= lddw_imm64_d;
            out_slots_q  <= 2'd2;
            out_err_q    <= hi_malformed_d;
            out_valid_q  <= 1'b1;
            state_q      <= S_FIRST;
          end
          default: state_q <= S_FIRST;
        endcase
      end
    end
  end

  assign out_opcode = out_opcode_q;
  assign out_dst    = out_dst_q;
  assign out_src    = out_src_q;
  assign out_off64  = out_off64_q;
  assign out_imm64  = out_imm64_q;
  assign out_slots  = out_slots_q;
  assign out_err    = out_err_q;
  assign out_valid  = out_valid_q;

endmodule
